// File: rtl/bus_timer_slave.sv
// Memory-mapped 64-bit timer with prescaler, compare match, pending flag and level interrupt.
// Single-cycle write grant; registered read data that holds until the next granted read.
module bus_timer_slave #(
  parameter int PRESCALE_W = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rd_req,
  output logic        rd_gnt,
  input  logic [31:0] rd_addr,
  output logic [31:0] rd_data,
  input  logic        wr_req,
  output logic        wr_gnt,
  input  logic [31:0] wr_addr,
  input  logic [31:0] wr_data,
  input  logic [3:0]  wr_be,
  output logic        irq
);

  localparam logic [PRESCALE_W-1:0] PSC_ONE = PRESCALE_W'(1);

  logic                  en;
  logic                  ie;
  logic                  auto_clr;
  logic [PRESCALE_W-1:0] psc;
  logic [PRESCALE_W-1:0] pre_cnt;
  logic                  pend;
  logic [63:0]           cnt;
  logic [63:0]           cmp;

  logic [2:0]  wsel;
  logic [31:0] wmask;
  logic [31:0] ctrl_word;
  logic [31:0] ctrl_nxt;
  logic [31:0] rd_mux;
  logic        tick;
  logic        match;
  logic [63:0] cnt_tick;
  logic [63:0] cnt_nxt;

  // only address bits [4:2] select a register
  logic unused_addr_bits;
  assign unused_addr_bits = ^{rd_addr[31:5], rd_addr[1:0], wr_addr[31:5], wr_addr[1:0]};

  function automatic logic [31:0] merge(input logic [31:0] old_v,
                                        input logic [31:0] new_v,
                                        input logic [31:0] mask);
    return (old_v & ~mask) | (new_v & mask);
  endfunction

  assign wr_gnt = wr_req;
  assign rd_gnt = rd_req & ~wr_req;
  assign wsel   = wr_addr[4:2];
  assign wmask  = {{8{wr_be[3]}}, {8{wr_be[2]}}, {8{wr_be[1]}}, {8{wr_be[0]}}};
  assign irq    = pend & ie;

  always_comb begin
    ctrl_word                  = '0;
    ctrl_word[0]               = en;
    ctrl_word[1]               = ie;
    ctrl_word[2]               = auto_clr;
    ctrl_word[8 +: PRESCALE_W] = psc;
  end

  assign ctrl_nxt = merge(ctrl_word, wr_data, wmask);

  always_comb begin
    rd_mux = '0;
    case (rd_addr[4:2])
      3'd0:    rd_mux = ctrl_word;
      3'd1:    rd_mux = {31'd0, pend};
      3'd2:    rd_mux = cnt[31:0];
      3'd3:    rd_mux = cnt[63:32];
      3'd4:    rd_mux = cmp[31:0];
      3'd5:    rd_mux = cmp[63:32];
      default: rd_mux = '0;
    endcase
  end

  assign tick  = en && (pre_cnt == psc);
  assign match = tick && (cnt == cmp);

  // bus bytes override the tick-updated counter; untouched bytes keep the tick result
  always_comb begin
    if (tick) cnt_tick = (match && auto_clr) ? 64'd0 : cnt + 64'd1;
    else      cnt_tick = cnt;
    cnt_nxt = cnt_tick;
    if (wr_req && wsel == 3'd2) cnt_nxt[31:0]  = merge(cnt_tick[31:0],  wr_data, wmask);
    if (wr_req && wsel == 3'd3) cnt_nxt[63:32] = merge(cnt_tick[63:32], wr_data, wmask);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en       <= 1'b0;
      ie       <= 1'b0;
      auto_clr <= 1'b0;
      psc      <= '0;
      pre_cnt  <= '0;
      pend     <= 1'b0;
      cnt      <= 64'd0;
      cmp      <= '1;
      rd_data  <= 32'd0;
    end else begin
      pre_cnt <= (!en || tick) ? '0 : pre_cnt + PSC_ONE;
      cnt     <= cnt_nxt;

      // a match in the same cycle as a clear keeps the flag set
      if (match)
        pend <= 1'b1;
      else if (wr_req && wsel == 3'd1 && wr_be[0] && wr_data[0])
        pend <= 1'b0;

      if (wr_req && wsel == 3'd0) begin
        en       <= ctrl_nxt[0];
        ie       <= ctrl_nxt[1];
        auto_clr <= ctrl_nxt[2];
        psc      <= ctrl_nxt[8 +: PRESCALE_W];
      end
      if (wr_req && wsel == 3'd4) cmp[31:0]  <= merge(cmp[31:0],  wr_data, wmask);
      if (wr_req && wsel == 3'd5) cmp[63:32] <= merge(cmp[63:32], wr_data, wmask);

      if (rd_gnt) rd_data <= rd_mux;
    end
  end

endmodule

// File: tb/tb_bus_timer_slave.sv
// Self-checking bench for bus_timer_slave: directed scenarios plus randomized bus traffic
// compared cycle by cycle against a register-level reference model.
module tb_bus_timer_slave;

  logic        clk = 1'b0;
  logic        rst;
  logic        rd_req;
  logic        rd_gnt;
  logic [31:0] rd_addr;
  logic [31:0] rd_data;
  logic        wr_req;
  logic        wr_gnt;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic [3:0]  wr_be;
  logic        irq;

  int n_pass  = 0;
  int n_total = 0;

  // reference model state: register contents as software sees them
  logic [31:0] m_ctrl;
  logic        m_pend;
  logic [63:0] m_cnt;
  logic [63:0] m_cmp;
  logic [7:0]  m_pre;
  logic [31:0] m_rd;

  bus_timer_slave #(.PRESCALE_W(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .rd_req  (rd_req),
    .rd_gnt  (rd_gnt),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .wr_req  (wr_req),
    .wr_gnt  (wr_gnt),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .wr_be   (wr_be),
    .irq     (irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [31:0] m_reg(input logic [2:0] a);
    case (a)
      3'd0:    return m_ctrl;
      3'd1:    return {31'd0, m_pend};
      3'd2:    return m_cnt[31:0];
      3'd3:    return m_cnt[63:32];
      3'd4:    return m_cmp[31:0];
      3'd5:    return m_cmp[63:32];
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_reset();
    m_ctrl = 32'd0;
    m_pend = 1'b0;
    m_cnt  = 64'd0;
    m_cmp  = '1;
    m_pre  = 8'd0;
    m_rd   = 32'd0;
  endtask

  // one bus cycle: starts just after a rising edge, ends 1 time unit after the next
  task automatic op(input logic rq, input logic [2:0] ra, input logic wq, input logic [2:0] wa,
                    input logic [31:0] wd, input logic [3:0] be);
    logic [31:0] r1, r2, rv, cur;
    logic        tick, hit;
    r1 = $urandom();
    r2 = $urandom();
    rd_req  = rq;
    rd_addr = {r1[31:5], ra, r1[1:0]};
    wr_req  = wq;
    wr_addr = {r2[31:5], wa, r2[1:0]};
    wr_data = wd;
    wr_be   = be;
    #1;
    chk("rd_gnt", rd_gnt, rq && !wq);
    chk("wr_gnt", wr_gnt, wq);

    tick = m_ctrl[0] && (m_pre == m_ctrl[15:8]);
    hit  = tick && (m_cnt == m_cmp);
    rv   = m_reg(ra);
    if (!m_ctrl[0] || tick) m_pre = 8'd0;
    else                    m_pre = m_pre + 8'd1;
    if (tick) m_cnt = (hit && m_ctrl[2]) ? 64'd0 : m_cnt + 64'd1;
    if (hit)  m_pend = 1'b1;
    if (wq) begin
      cur = m_reg(wa);
      for (int b = 0; b < 4; b++)
        if (be[b]) cur[8*b +: 8] = wd[8*b +: 8];
      case (wa)
        3'd0: m_ctrl = cur & 32'h0000_FF07;
        3'd1: if (be[0] && wd[0] && !hit) m_pend = 1'b0;
        3'd2: m_cnt[31:0]  = cur;
        3'd3: m_cnt[63:32] = cur;
        3'd4: m_cmp[31:0]  = cur;
        3'd5: m_cmp[63:32] = cur;
        default: ;
      endcase
    end
    if (rq && !wq) m_rd = rv;

    @(posedge clk);
    #1;
    chk("rd_data", rd_data, m_rd);
    chk("irq", irq, m_pend & m_ctrl[1]);
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    op(1'b0, 3'd0, 1'b1, a, d, 4'hF);
  endtask

  task automatic rd(input logic [2:0] a);
    op(1'b1, a, 1'b0, 3'd0, 32'd0, 4'h0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) op(1'b0, 3'd0, 1'b0, 3'd0, 32'd0, 4'h0);
  endtask

  // synchronous-looking reset pulse with a write attempted while it is held
  task automatic do_reset();
    rst     = 1'b1;
    rd_req  = 1'b0;
    wr_req  = 1'b1;
    wr_addr = 32'h0;
    wr_data = 32'h0000_0003;
    wr_be   = 4'hF;
    #1;
    chk("rst_wr_gnt", wr_gnt, 1'b1);
    @(posedge clk);
    #1;
    wr_req = 1'b0;
    rst    = 1'b0;
    model_reset();
    chk("rst_rd_data", rd_data, 32'd0);
    chk("rst_irq", irq, 1'b0);
    rd(3'd0);
    chk("rst_ctrl", rd_data, 32'd0);
  endtask

  initial begin
    logic [2:0]  a;
    logic [31:0] d;
    logic [3:0]  be;
    rst = 1'b1; rd_req = 1'b0; wr_req = 1'b0;
    rd_addr = '0; wr_addr = '0; wr_data = '0; wr_be = '0;
    @(posedge clk);
    #1;
    do_reset();
    rd(3'd4);
    chk("rst_cmp_lo", rd_data, 32'hFFFF_FFFF);

    // compare at 5, prescale off: pending one cycle after the matching tick
    wr(3'd4, 32'd5); wr(3'd5, 32'd0); wr(3'd0, 32'h0000_0003);
    idle(5);
    chk("s1_irq_before", irq, 1'b0);
    idle(1);
    chk("s1_irq_after", irq, 1'b1);
    rd(3'd1);
    chk("s1_pend", rd_data, 32'd1);
    rd(3'd2);
    chk("s1_cnt_ge7", rd_data >= 32'd7, 1'b1);

    // prescale 4, auto-clear at 2
    do_reset();
    wr(3'd4, 32'd2); wr(3'd5, 32'd0); wr(3'd0, 32'h0000_0305);
    for (int i = 0; i < 30; i++) begin
      rd(3'd2);
      chk("s2_cnt_le2", rd_data <= 32'd2, 1'b1);
    end
    rd(3'd1);
    chk("s2_pend", rd_data, 32'd1);

    // carry from low into high word
    do_reset();
    wr(3'd2, 32'hFFFF_FFFE); wr(3'd0, 32'h0000_0001);
    idle(1);
    wr(3'd0, 32'h0000_0000);
    rd(3'd3);
    chk("s3_cnt_hi", rd_data, 32'd1);
    rd(3'd2);
    chk("s3_cnt_lo", rd_data, 32'd0);

    // write beats read; the retried read sees the new value
    op(1'b1, 3'd4, 1'b1, 3'd4, 32'h0000_A5A5, 4'hF);
    chk("s4_rd_held", rd_data, 32'd0);
    rd(3'd4);
    chk("s4_rd_new", rd_data, 32'h0000_A5A5);

    // clear colliding with a match loses; a later clear wins
    do_reset();
    wr(3'd4, 32'd3); wr(3'd5, 32'd0); wr(3'd0, 32'h0000_0003);
    idle(3);
    op(1'b0, 3'd0, 1'b1, 3'd1, 32'd1, 4'hF);
    chk("s5_irq_kept", irq, 1'b1);
    wr(3'd1, 32'd1);
    chk("s5_irq_clr", irq, 1'b0);
    rd(3'd1);
    chk("s5_pend_clr", rd_data, 32'd0);

    // asynchronous reset in the middle of a cycle
    wr(3'd2, 32'h0000_1234); wr(3'd3, 32'd0);
    wr(3'd4, 32'h0000_1240); wr(3'd5, 32'd0); wr(3'd0, 32'h0000_0003);
    idle(20);
    rd(3'd4);
    chk("s6_irq_pre", irq, 1'b1);
    chk("s6_rd_pre", rd_data, 32'h0000_1240);
    #2;
    rst = 1'b1;
    #1;
    chk("s6_async_rd_data", rd_data, 32'd0);
    chk("s6_async_irq", irq, 1'b0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    rd(3'd2); chk("s6_cnt_lo", rd_data, 32'd0);
    rd(3'd3); chk("s6_cnt_hi", rd_data, 32'd0);
    rd(3'd1); chk("s6_pend", rd_data, 32'd0);
    rd(3'd4); chk("s6_cmp_lo", rd_data, 32'hFFFF_FFFF);
    rd(3'd5); chk("s6_cmp_hi", rd_data, 32'hFFFF_FFFF);

    // randomized traffic against the model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      a  = 3'($urandom_range(0, 7));
      be = ($urandom_range(0, 1) == 1) ? 4'hF : 4'($urandom_range(0, 15));
      case (a)
        3'd0:                d = $urandom() & 32'hFFFF_03FF;
        3'd2, 3'd3, 3'd4, 3'd5:
          d = ($urandom_range(0, 3) == 0) ? $urandom() : 32'($urandom_range(0, 15));
        default:             d = $urandom();
      endcase
      op(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
         ($urandom_range(0, 2) == 0), a, d, be);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
